// File: rtl/ram_cmd_ctrl.sv
// Command queue and issue stage in front of a synchronous single-port RAM.
// Optional macro RAM_CMD_CTRL_CNT_EN adds issued-write and read-response counters.
`timescale 1ns/1ps
module ram_cmd_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rwn,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       RWn,
    output logic [7:0] waddr,
    output logic [7:0] wdata,
    output logic [7:0] raddr,
    input  logic [7:0] rdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_addr,
    output logic [7:0] rsp_data
`ifdef RAM_CMD_CTRL_CNT_EN
    ,
    output logic [15:0] wr_cnt,
    output logic [15:0] rd_cnt
`endif
);

    logic       fifo_rwn   [4];
    logic [7:0] fifo_addr  [4];
    logic [7:0] fifo_wdata [4];
    logic [1:0] wptr_q, rptr_q;
    logic [2:0] count_q, count_d;
    logic       push, pop;

    logic       rwn_q;
    logic [7:0] waddr_q, wdata_q, raddr_q;
    logic       rd_pend_q, ram_pend_q;
    logic [7:0] ram_addr_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_addr_q, rsp_data_q;

    // Ready comes from registered count only, so a full queue never passes through.
    assign cmd_ready = (count_q < 3'd4);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (count_q != 3'd0);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rwn[wptr_q]   <= cmd_rwn;
            fifo_addr[wptr_q]  <= cmd_addr;
            fifo_wdata[wptr_q] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            count_q <= 3'd0;
        end else begin
            if (push) wptr_q <= wptr_q + 2'd1;
            if (pop)  rptr_q <= rptr_q + 2'd1;
            count_q <= count_d;
        end
    end

    // Issue stage: an idle cycle is a harmless read of the held address.
    always_ff @(posedge clk) begin
        if (rst) begin
            rwn_q     <= 1'b1;
            waddr_q   <= 8'd0;
            wdata_q   <= 8'd0;
            raddr_q   <= 8'd0;
            rd_pend_q <= 1'b0;
        end else if (pop) begin
            rwn_q     <= fifo_rwn[rptr_q];
            rd_pend_q <= fifo_rwn[rptr_q];
            if (fifo_rwn[rptr_q]) begin
                raddr_q <= fifo_addr[rptr_q];
            end else begin
                waddr_q <= fifo_addr[rptr_q];
                wdata_q <= fifo_wdata[rptr_q];
            end
        end else begin
            rwn_q     <= 1'b1;
            rd_pend_q <= 1'b0;
        end
    end

    // RAM samples the read one edge after issue; rdata is captured the edge after that.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_pend_q  <= 1'b0;
            ram_addr_q  <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= 8'd0;
            rsp_data_q  <= 8'd0;
        end else begin
            ram_pend_q  <= rd_pend_q;
            ram_addr_q  <= raddr_q;
            rsp_valid_q <= ram_pend_q;
            if (ram_pend_q) begin
                rsp_addr_q <= ram_addr_q;
                rsp_data_q <= rdata;
            end
        end
    end

    assign RWn       = rwn_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign raddr     = raddr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data  = rsp_data_q;

`ifdef RAM_CMD_CTRL_CNT_EN
    logic [15:0] wr_cnt_q, rd_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q <= 16'd0;
            rd_cnt_q <= 16'd0;
        end else begin
            if (pop && !fifo_rwn[rptr_q]) wr_cnt_q <= wr_cnt_q + 16'd1;
            if (ram_pend_q)               rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// Randomized bench for ram_cmd_ctrl against a command-level timing/data model.
`timescale 1ns/1ps
module tb_ram_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_rwn;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       RWn;
    logic [7:0] waddr, wdata, raddr, rdata;
    logic       rsp_valid;
    logic [7:0] rsp_addr, rsp_data;
`ifdef RAM_CMD_CTRL_CNT_EN
    logic [15:0] wr_cnt, rd_cnt;
`endif

    ram_cmd_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rwn   (cmd_rwn),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .RWn       (RWn),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .rsp_valid (rsp_valid),
        .rsp_addr  (rsp_addr),
        .rsp_data  (rsp_data)
`ifdef RAM_CMD_CTRL_CNT_EN
        ,
        .wr_cnt    (wr_cnt),
        .rd_cnt    (rd_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous RAM: write when RWn = 0, otherwise registered read.
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (!RWn) ram[waddr] <= wdata;
        else      rdata <= ram[raddr];
    end

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int         e;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_wr[$];
    ev_t        exp_rsp[$];
    int         iss_q[$];
    int         last_issue;
    logic [7:0] mdl_mem [256];
    int         mdl_wr, mdl_rd;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Compare every RAM-side and response output against the model for this cycle.
    task automatic check_outputs();
        logic exp_rwn;
        exp_rwn = 1'b1;
        if (exp_wr.size() > 0 && exp_wr[0].e == edge_n) begin
            exp_rwn = 1'b0;
            check("waddr", {8'd0, waddr}, {8'd0, exp_wr[0].addr});
            check("wdata", {8'd0, wdata}, {8'd0, exp_wr[0].data});
            void'(exp_wr.pop_front());
        end
        check("RWn", {15'd0, RWn}, {15'd0, exp_rwn});
        foreach (exp_rsp[i]) begin
            if (exp_rsp[i].e == edge_n + 2) check("raddr", {8'd0, raddr}, {8'd0, exp_rsp[i].addr});
        end
        if (exp_rsp.size() > 0 && exp_rsp[0].e == edge_n) begin
            check("rsp_valid", {15'd0, rsp_valid}, 16'd1);
            check("rsp_addr", {8'd0, rsp_addr}, {8'd0, exp_rsp[0].addr});
            check("rsp_data", {8'd0, rsp_data}, {8'd0, exp_rsp[0].data});
            void'(exp_rsp.pop_front());
        end else begin
            check("rsp_valid", {15'd0, rsp_valid}, 16'd0);
        end
    endtask

    // One clock: predict ready, offer a command, advance, then check outputs.
    task automatic step(input logic v, input logic rwn, input logic [7:0] addr,
                        input logic [7:0] data);
        logic ready_exp;
        int   a, ie;
        while (iss_q.size() > 0 && iss_q[0] <= edge_n) void'(iss_q.pop_front());
        ready_exp = (iss_q.size() < 4);
        check("cmd_ready", {15'd0, cmd_ready}, {15'd0, ready_exp});
        cmd_valid = v;
        cmd_rwn   = rwn;
        cmd_addr  = addr;
        cmd_wdata = data;
        if (v && ready_exp) begin
            a  = edge_n + 1;
            ie = (a + 1 > last_issue + 1) ? a + 1 : last_issue + 1;
            last_issue = ie;
            iss_q.push_back(ie);
            if (rwn) begin
                exp_rsp.push_back('{ie + 2, addr, mdl_mem[addr]});
                mdl_rd++;
            end else begin
                mdl_mem[addr] = data;
                exp_wr.push_back('{ie, addr, data});
                mdl_wr++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'd0, 8'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_wr.delete();
        exp_rsp.delete();
        iss_q.delete();
        last_issue = edge_n;
        mdl_wr     = 0;
        mdl_rd     = 0;
        // Writes already at the RAM by the reset edge are real; resync from the RAM.
        for (int i = 0; i < 256; i++) mdl_mem[i] = ram[i];
        check("rst_RWn", {15'd0, RWn}, 16'd1);
        check("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i * 3 + 1);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_rwn   = 1'b1;
        cmd_addr  = 8'd0;
        cmd_wdata = 8'd0;
        @(negedge clk);
        do_reset();
        check("rst_waddr", {8'd0, waddr}, 16'd0);
        check("rst_wdata", {8'd0, wdata}, 16'd0);
        check("rst_raddr", {8'd0, raddr}, 16'd0);
        check("rst_rsp_addr", {8'd0, rsp_addr}, 16'd0);
        check("rst_rsp_data", {8'd0, rsp_data}, 16'd0);
        check("rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);

        // Write then read of the same address.
        step(1'b1, 1'b0, 8'd5, 8'd29);
        step(1'b1, 1'b1, 8'd5, 8'd0);
        idle(5);
        // Single read latency.
        step(1'b1, 1'b1, 8'd2, 8'd0);
        idle(5);
        // Six back-to-back commands, order preserved.
        step(1'b1, 1'b0, 8'd10, 8'hA1);
        step(1'b1, 1'b1, 8'd10, 8'd0);
        step(1'b1, 1'b0, 8'd11, 8'hB2);
        step(1'b1, 1'b0, 8'd10, 8'hC3);
        step(1'b1, 1'b1, 8'd11, 8'd0);
        step(1'b1, 1'b1, 8'd10, 8'd0);
        idle(5);
        // Back-to-back reads.
        step(1'b1, 1'b1, 8'd1, 8'd0);
        step(1'b1, 1'b1, 8'd2, 8'd0);
        step(1'b1, 1'b1, 8'd3, 8'd0);
        idle(5);
        // Reset one cycle after a read issues: response must be dropped.
        step(1'b1, 1'b1, 8'd7, 8'd0);
        step(1'b0, 1'b1, 8'd0, 8'd0);
        do_reset();
        idle(5);

`ifdef RAM_CMD_CTRL_CNT_EN
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(20 + i), 8'(i));
        step(1'b1, 1'b1, 8'd20, 8'd0);
        step(1'b1, 1'b1, 8'd21, 8'd0);
        idle(6);
        check("wr_cnt", wr_cnt, 16'd3);
        check("rd_cnt", rd_cnt, 16'd2);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom_range(0, 15)),
                     8'($urandom));
            end
        end

        for (int i = 0; i < 20 && (exp_wr.size() + exp_rsp.size()) > 0; i++) idle(1);
        check("drained", 16'(exp_wr.size() + exp_rsp.size()), 16'd0);
`ifdef RAM_CMD_CTRL_CNT_EN
        check("wr_cnt_end", wr_cnt, 16'(mdl_wr));
        check("rd_cnt_end", rd_cnt, 16'(mdl_rd));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
